// File: rtl/reg_wb_ctrl.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and
// multi-cycle results are queued in a FIFO. Build option: WB_STARVE_GUARD_EN.
module reg_wb_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_valid,
    input  logic [ADDR_W-1:0]          pipe_rd,
    input  logic [DATA_W-1:0]          pipe_data,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [ADDR_W-1:0]          mc_rd,
    input  logic [DATA_W-1:0]          mc_data,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          look_addr_1,
    input  logic [ADDR_W-1:0]          look_addr_2,
    output logic                       look_hit_1,
    output logic                       look_hit_2,
    output logic [DATA_W-1:0]          look_data_1,
    output logic [DATA_W-1:0]          look_data_2,
    output logic [$clog2(DEPTH):0]     pending_cnt,
    output logic                       pipe_stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [DEPTH-1:0]  ent_vld_reg;
    logic [ADDR_W-1:0] ent_rd_reg   [DEPTH];
    logic [DATA_W-1:0] ent_data_reg [DEPTH];

    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;

    logic              pipe_accept;
    logic              enq_store;
    logic              enq_squash;
    logic              pop;
    logic [DEPTH-1:0]  squash_hit;

    // Ready comes from the registered count only, so a pop cannot reopen it in the same cycle.
    assign mc_ready    = rst_n & (count_reg != CNT_W'(DEPTH));
    assign enq_store   = mc_valid & mc_ready & (mc_rd != '0);
    assign pipe_accept = pipe_valid & ~pipe_stall & (pipe_rd != '0);
    assign pop         = ~pipe_accept & (count_reg != '0);
    assign enq_squash  = pipe_accept & (mc_rd == pipe_rd);
    assign count_next  = count_reg + CNT_W'(enq_store) - CNT_W'(pop);

    // An accepted pipe write is younger than everything queued: kill older same-rd entries.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
            assign squash_hit[gi] = pipe_accept && (ent_rd_reg[gi] == pipe_rd);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            ent_vld_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (enq_store) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (enq_store && (tail_reg == PTR_W'(j))) begin
                    ent_vld_reg[j] <= ~enq_squash;
                end else if (squash_hit[j]) begin
                    ent_vld_reg[j] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_store) begin
            ent_rd_reg[tail_reg]   <= mc_rd;
            ent_data_reg[tail_reg] <= mc_data;
        end
    end

    // Output stage: a squashed head still pops, but produces no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else if (pipe_accept) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= pipe_rd;
            wr_data_reg <= pipe_data;
        end else if (pop) begin
            wr_en_reg   <= ent_vld_reg[head_reg];
            wr_addr_reg <= ent_rd_reg[head_reg];
            wr_data_reg <= ent_data_reg[head_reg];
        end else begin
            wr_en_reg   <= 1'b0;
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign pending_cnt = count_reg;

    logic [ADDR_W-1:0] look_addr_arr [2];
    logic [1:0]        look_hit_vec;
    logic [DATA_W-1:0] look_data_arr [2];

    assign look_addr_arr[0] = look_addr_1;
    assign look_addr_arr[1] = look_addr_2;

    // Oldest-to-youngest scan so the last match (the youngest) wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_look
            logic [PTR_W-1:0]  idx;
            logic              hit_c;
            logic [DATA_W-1:0] data_c;

            always_comb begin
                idx    = '0;
                hit_c  = wr_en_reg && (wr_addr_reg == look_addr_arr[gi]);
                data_c = wr_data_reg;
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head_reg + PTR_W'(i);
                    if ((CNT_W'(i) < count_reg) && ent_vld_reg[idx] &&
                        (ent_rd_reg[idx] == look_addr_arr[gi])) begin
                        hit_c  = 1'b1;
                        data_c = ent_data_reg[idx];
                    end
                end
                if (look_addr_arr[gi] == '0) begin
                    hit_c = 1'b0;
                end
                if (!hit_c) begin
                    data_c = '0;
                end
            end

            assign look_hit_vec[gi]  = hit_c;
            assign look_data_arr[gi] = data_c;
        end
    endgenerate

    assign look_hit_1  = look_hit_vec[0];
    assign look_hit_2  = look_hit_vec[1];
    assign look_data_1 = look_data_arr[0];
    assign look_data_2 = look_data_arr[1];

`ifdef WB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_reg;

    // Stall lands on the LIMIT-th consecutive cycle of pipe writes blocking a non-empty queue.
    assign pipe_stall = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT - 1)) && (count_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (pop || (count_next == '0)) begin
            starve_cnt_reg <= '0;
        end else if (pipe_accept && (count_reg != '0)) begin
            starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
        end
    end
`else
    assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed vector bench for reg_wb_ctrl; the starvation sequence follows WB_STARVE_GUARD_EN.
module tb_reg_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  look_addr_1;
    logic [4:0]  look_addr_2;
    logic        look_hit_1;
    logic        look_hit_2;
    logic [31:0] look_data_1;
    logic [31:0] look_data_2;
    logic [2:0]  pending_cnt;
    logic        pipe_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_wb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .look_addr_1 (look_addr_1),
        .look_addr_2 (look_addr_2),
        .look_hit_1  (look_hit_1),
        .look_hit_2  (look_hit_2),
        .look_data_1 (look_data_1),
        .look_data_2 (look_data_2),
        .pending_cnt (pending_cnt),
        .pipe_stall  (pipe_stall)
    );

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic [4:0]  la1;
        logic [4:0]  la2;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rdy;
        logic [2:0]  cnt;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
        input logic [4:0] la1, input logic [4:0] la2,
        input logic en, input logic [4:0] addr, input logic [31:0] data,
        input logic rdy, input logic [2:0] cnt,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pdat = pdat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.la1 = la1; v.la2 = la2;
        v.en = en; v.addr = addr; v.data = data;
        v.rdy = rdy; v.cnt = cnt;
        v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pdat;
        mc_valid = mv; mc_rd = mrd; mc_data = mdat;
    endtask

    logic        exp_stall;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_cnt;
    logic        exp_en;
    logic        guard_on;

    initial begin
`ifdef WB_STARVE_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        //                 pv prd   pdat          mv mrd  mdat    la1 la2 | en addr data         rdy cnt h1 d1            h2 d2
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,      5,  0,    1, 5,  32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      5,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 3,  32'h11, 3,  0,    0, 0,  0,            1, 1, 1, 32'h11,       0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 4,  32'h22, 3,  4,    1, 3,  32'h11,       1, 1, 1, 32'h11,       1, 32'h22));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      4,  0,    1, 4,  32'h22,       1, 0, 1, 32'h22,       0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      4,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 10, 32'hA0,       1, 20, 32'h100, 0, 0,    1, 10, 32'hA0,       1, 1, 0, 0,            0, 0));
        vecs.push_back(mk(1, 11, 32'hA1,       1, 21, 32'h101, 0, 0,    1, 11, 32'hA1,       1, 2, 0, 0,            0, 0));
        vecs.push_back(mk(1, 12, 32'hA2,       1, 22, 32'h102, 0, 0,    1, 12, 32'hA2,       1, 3, 0, 0,            0, 0));
        vecs.push_back(mk(1, 13, 32'hA3,       1, 23, 32'h103, 20, 23,  1, 13, 32'hA3,       0, 4, 1, 32'h100,      1, 32'h103));
        vecs.push_back(mk(1, 14, 32'hA4,       1, 24, 32'h104, 24, 0,   1, 14, 32'hA4,       0, 4, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      20, 0,    1, 20, 32'h100,      1, 3, 1, 32'h100,      0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    1, 21, 32'h101,      1, 2, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    1, 22, 32'h102,      1, 1, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      24, 0,    1, 23, 32'h103,      1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 7,  32'hAA, 7,  0,    0, 0,  0,            1, 1, 1, 32'hAA,       0, 0));
        vecs.push_back(mk(1, 7,  32'hBB,       0, 0,  0,      7,  0,    1, 7,  32'hBB,       1, 1, 1, 32'hBB,       0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      7,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 9,  32'hC1,       1, 9,  32'hC0, 9,  0,    1, 9,  32'hC1,       1, 1, 1, 32'hC1,       0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      9,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 6,  32'h61, 6,  0,    0, 0,  0,            1, 1, 1, 32'h61,       0, 0));
        vecs.push_back(mk(1, 2,  32'h20,       1, 6,  32'h62, 6,  2,    1, 2,  32'h20,       1, 2, 1, 32'h62,       1, 32'h20));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      6,  0,    1, 6,  32'h61,       1, 1, 1, 32'h62,       0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      6,  0,    1, 6,  32'h62,       1, 0, 1, 32'h62,       0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(1, 0,  32'h55,       1, 0,  32'h66, 0,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 8,  32'h88, 8,  0,    0, 0,  0,            1, 1, 1, 32'h88,       0, 0));
        vecs.push_back(mk(1, 0,  32'h99,       0, 0,  0,      0,  0,    1, 8,  32'h88,       1, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,      0,  0,    0, 0,  0,            1, 0, 0, 0,            0, 0));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        look_addr_1 = '0;
        look_addr_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_pending", 32'(pending_cnt), 0);
        chk("reset_mc_ready", 32'(mc_ready), 0);
        chk("reset_pipe_stall", 32'(pipe_stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].prd, vecs[i].pdat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
            look_addr_1 = vecs[i].la1;
            look_addr_2 = vecs[i].la2;
            @(posedge clk);
            #1;
            $display("vec %0d: wr_en=%0b wr_addr=%0d wr_data=0x%0h pending=%0d mc_ready=%0b hit1=%0b hit2=%0b",
                     i, wr_en, wr_addr, wr_data, pending_cnt, mc_ready, look_hit_1, look_hit_2);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
            if (vecs[i].en) begin
                chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].data);
            end
            chk($sformatf("v%0d_mc_ready", i), 32'(mc_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_pending", i), 32'(pending_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_hit1", i), 32'(look_hit_1), 32'(vecs[i].h1));
            chk($sformatf("v%0d_hit2", i), 32'(look_hit_2), 32'(vecs[i].h2));
            if (vecs[i].h1) chk($sformatf("v%0d_data1", i), look_data_1, vecs[i].d1);
            if (vecs[i].h2) chk($sformatf("v%0d_data2", i), look_data_2, vecs[i].d2);
        end

        // Starvation: one queued entry, pipe writes every cycle.
        @(negedge clk);
        drive(0, 0, 0, 1, 15, 32'h1F5);
        look_addr_1 = '0;
        look_addr_2 = '0;
        @(posedge clk);
        #1;
        chk("starve_setup_pending", 32'(pending_cnt), 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            drive(1, 17, 32'(k), 0, 0, 0);
            #1;
            exp_stall = guard_on && (k == 8);
            chk($sformatf("starve_k%0d_stall", k), 32'(pipe_stall), 32'(exp_stall));
            @(posedge clk);
            #1;
            exp_addr = exp_stall ? 5'd15 : 5'd17;
            exp_data = exp_stall ? 32'h1F5 : 32'(k);
            exp_cnt  = (guard_on && (k >= 8)) ? 3'd0 : 3'd1;
            $display("starve k=%0d: pipe_stall=%0b wr_addr=%0d wr_data=0x%0h pending=%0d",
                     k, pipe_stall, wr_addr, wr_data, pending_cnt);
            chk($sformatf("starve_k%0d_wr_en", k), 32'(wr_en), 1);
            chk($sformatf("starve_k%0d_wr_addr", k), 32'(wr_addr), 32'(exp_addr));
            chk($sformatf("starve_k%0d_wr_data", k), wr_data, exp_data);
            chk($sformatf("starve_k%0d_pending", k), 32'(pending_cnt), 32'(exp_cnt));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        exp_en = !guard_on;
        $display("starve drain: wr_en=%0b wr_addr=%0d pending=%0d", wr_en, wr_addr, pending_cnt);
        chk("starve_drain_wr_en", 32'(wr_en), 32'(exp_en));
        if (exp_en) chk("starve_drain_wr_addr", 32'(wr_addr), 15);
        chk("starve_drain_pending", 32'(pending_cnt), 0);

        // Asynchronous reset with two entries queued.
        @(negedge clk);
        drive(1, 30, 32'h300, 1, 25, 32'h250);
        @(negedge clk);
        drive(1, 31, 32'h310, 1, 26, 32'h260);
        @(posedge clk);
        #1;
        chk("rstmid_pending_before", 32'(pending_cnt), 2);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        look_addr_1 = 5'd25;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: wr_en=%0b pending=%0d mc_ready=%0b", wr_en, pending_cnt, mc_ready);
        chk("rstmid_wr_en", 32'(wr_en), 0);
        chk("rstmid_wr_addr", 32'(wr_addr), 0);
        chk("rstmid_wr_data", wr_data, 0);
        chk("rstmid_pending", 32'(pending_cnt), 0);
        chk("rstmid_mc_ready", 32'(mc_ready), 0);
        chk("rstmid_hit1", 32'(look_hit_1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_after_wr_en", 32'(wr_en), 0);
        chk("rstmid_after_pending", 32'(pending_cnt), 0);
        chk("rstmid_after_mc_ready", 32'(mc_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
